// File: rtl/tick_timer_if.sv
// tick_timer_if: signal bundle between a tick_timer and its controller.
// The sticky interrupt pair exists only when TICK_TIMER_STICKY_IRQ_EN is defined.
// Handshake: start, stop and tick are one-cycle requests. The timer samples them
// on every rising clock edge and never applies backpressure, so there is no
// ready signal. pause is a level input. count, busy, done and irq are status outputs.
interface tick_timer_if #(
  parameter int W = 8
);
  logic         tick;
  logic         start;
  logic         stop;
  logic         pause;
  logic         periodic;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
`ifdef TICK_TIMER_STICKY_IRQ_EN
  logic         irq_ack;
  logic         irq;
`endif

  modport master (
    output tick, start, stop, pause, periodic, load_val,
    input  count, busy, done
`ifdef TICK_TIMER_STICKY_IRQ_EN
    , output irq_ack
    , input  irq
`endif
  );

  modport slave (
    input  tick, start, stop, pause, periodic, load_val,
    output count, busy, done
`ifdef TICK_TIMER_STICKY_IRQ_EN
    , input  irq_ack
    , output irq
`endif
  );
endinterface

// File: rtl/tick_timer.sv
// tick_timer: programmable countdown timer. Each enable tick from the upstream
// divider decrements the count. A one-cycle done pulse marks the 1->0 step.
// Supports one-shot and periodic (auto-reload) modes, pause/resume, and abort.
// Optional sticky interrupt: define TICK_TIMER_STICKY_IRQ_EN.
// Per-cycle priority: stop > start > pause > tick.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  tick_timer_if.slave  bus,
  output logic [1:0]   o_dbg_state
);
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSED = 2'b10;

  logic [1:0]   r_state, w_state_nxt;
  logic [W-1:0] r_count, w_count_nxt;
  logic [W-1:0] r_reload, w_reload_nxt;
  logic         r_mode, w_mode_nxt;
  logic         r_done, w_done_nxt;
  logic         w_load, w_abort, w_terminal;

  // A start with a zero load value cannot run, so while busy it acts as an abort.
  assign w_load     = bus.start && (bus.load_val != '0);
  assign w_abort    = bus.stop || (bus.start && (bus.load_val == '0));
  assign w_terminal = (r_count == W'(1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-datapath decision, applying stop > start > pause > tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.stop && w_load) begin
          w_count_nxt  = bus.load_val;
          w_reload_nxt = bus.load_val;
          w_mode_nxt   = bus.periodic;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_load) begin
          w_count_nxt  = bus.load_val;
          w_reload_nxt = bus.load_val;
          w_mode_nxt   = bus.periodic;
        end else if (bus.pause) begin
          w_state_nxt = ST_PAUSED;
        end else if (bus.tick) begin
          if (w_terminal) begin
            w_done_nxt = 1'b1;
            if (r_mode) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = ST_IDLE;
            end
          end else if (r_count != '0) begin
            w_count_nxt = r_count - W'(1);
          end
        end
      end
      ST_PAUSED: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_load) begin
          w_count_nxt  = bus.load_val;
          w_reload_nxt = bus.load_val;
          w_mode_nxt   = bus.periodic;
          w_state_nxt  = ST_RUN;
        end else if (!bus.pause) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: count, reload value, mode bit and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef TICK_TIMER_STICKY_IRQ_EN
  logic r_irq;

  // Sticky interrupt: set with done, cleared by ack; a set wins over an ack in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_irq <= 1'b0;
    else if (w_done_nxt)  r_irq <= 1'b1;
    else if (bus.irq_ack) r_irq <= 1'b0;
  end

  // Interrupt output drive.
  always_comb begin
    bus.irq = r_irq;
  end
`endif

  // Output decode: busy covers RUN and PAUSED; state is exposed for debug.
  always_comb begin
    bus.count   = r_count;
    bus.done    = r_done;
    bus.busy    = (r_state == ST_RUN) || (r_state == ST_PAUSED);
    o_dbg_state = r_state;
  end
endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: self-checking bench for tick_timer (optionally with TICK_TIMER_STICKY_IRQ_EN).
module tb_tick_timer;
  localparam int W  = 8;
  localparam int EW = W + 5;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  logic       w_irq;

  tick_timer_if #(.W(W)) u_if ();

  tick_timer #(.W(W)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (u_if.slave),
    .o_dbg_state (dbg_state)
  );

`ifdef TICK_TIMER_STICKY_IRQ_EN
  assign w_irq = u_if.irq;
`else
  assign w_irq = 1'b0;
`endif

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            m_state;   // 0 idle, 1 run, 2 paused
  int            m_count;
  int            m_reload;
  bit            m_periodic;
  bit            m_done;
  bit            m_irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] pack(input logic [1:0] s, input logic b,
                                         input logic d, input logic i, input logic [W-1:0] c);
    return {s, b, d, i, c};
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_reload = 0; m_periodic = 0; m_done = 0; m_irq = 0;
  endtask

  // One clock edge of the timer, written from the behavioural rules.
  task automatic model_edge(input bit t, input bit st, input bit sp, input bit p,
                            input bit per, input int lv, input bit ack);
    bit fire;
    fire = 0;
    if (m_state == 0) begin
      if (!sp && st && lv != 0) begin
        m_count = lv; m_reload = lv; m_periodic = per; m_state = 1;
      end
    end else if (sp || (st && lv == 0)) begin
      m_state = 0;
    end else if (st) begin
      m_count = lv; m_reload = lv; m_periodic = per; m_state = 1;
    end else if (m_state == 2) begin
      if (!p) m_state = 1;
    end else if (p) begin
      m_state = 2;
    end else if (t) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        fire = 1;
        if (m_periodic) m_count = m_reload;
        else m_state = 0;
      end
    end
    m_done = fire;
`ifdef TICK_TIMER_STICKY_IRQ_EN
    if (fire) m_irq = 1;
    else if (ack) m_irq = 0;
`endif
  endtask

  function automatic logic [EW-1:0] model_pack();
    return pack(m_state[1:0], m_state != 0, m_done, m_irq, m_count[W-1:0]);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string name);
    logic [EW-1:0] exp_v, act_v;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard queue empty", name);
      return;
    end
    exp_v = exp_q.pop_front();
    act_v = pack(dbg_state, u_if.busy, u_if.done, w_irq, u_if.count);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: {state,busy,done,irq,count} got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp_b);
    n_checks++;
    if (act !== exp_b) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_b);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic t, input logic st, input logic sp, input logic p,
                      input logic per, input logic [W-1:0] lv, input logic ack, input string name);
    u_if.tick = t; u_if.start = st; u_if.stop = sp; u_if.pause = p;
    u_if.periodic = per; u_if.load_val = lv;
`ifdef TICK_TIMER_STICKY_IRQ_EN
    u_if.irq_ack = ack;
`endif
    model_edge(t, st, sp, p, per, int'(lv), ack);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    check_outputs(name);
  endtask

  task automatic idle_inputs();
    u_if.tick = 0; u_if.start = 0; u_if.stop = 0; u_if.pause = 0;
    u_if.periodic = 0; u_if.load_val = '0;
`ifdef TICK_TIMER_STICKY_IRQ_EN
    u_if.irq_ack = 0;
`endif
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear at once.
  task automatic pulse_reset(input string name);
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_pack());
    check_outputs(name);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic         tick, start, stop, pause, periodic;
    logic [W-1:0] lv;
    logic [W-1:0] e_count;
    logic         e_busy, e_done;
    logic [1:0]   e_state;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic t, input logic st, input logic sp, input logic p,
                     input logic per, input int lv, input int ec, input logic eb,
                     input logic ed, input logic [1:0] es);
    vec_t v;
    v.tick = t; v.start = st; v.stop = sp; v.pause = p; v.periodic = per;
    v.lv = W'(lv); v.e_count = W'(ec); v.e_busy = eb; v.e_done = ed; v.e_state = es;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();

    // One-shot load 3, tick every third clock.
    add(0,1,0,0,0, 3, 3,1,0,2'b01);
    add(0,0,0,0,0, 0, 3,1,0,2'b01);
    add(0,0,0,0,0, 0, 3,1,0,2'b01);
    add(1,0,0,0,0, 0, 2,1,0,2'b01);
    add(0,0,0,0,0, 0, 2,1,0,2'b01);
    add(0,0,0,0,0, 0, 2,1,0,2'b01);
    add(1,0,0,0,0, 0, 1,1,0,2'b01);
    add(0,0,0,0,0, 0, 1,1,0,2'b01);
    add(0,0,0,0,0, 0, 1,1,0,2'b01);
    add(1,0,0,0,0, 0, 0,0,1,2'b00);
    add(0,0,0,0,0, 0, 0,0,0,2'b00);
    // Periodic load 2, six ticks, then stop.
    add(0,1,0,0,1, 2, 2,1,0,2'b01);
    add(1,0,0,0,0, 0, 1,1,0,2'b01);
    add(1,0,0,0,0, 0, 2,1,1,2'b01);
    add(1,0,0,0,0, 0, 1,1,0,2'b01);
    add(1,0,0,0,0, 0, 2,1,1,2'b01);
    add(1,0,0,0,0, 0, 1,1,0,2'b01);
    add(1,0,0,0,0, 0, 2,1,1,2'b01);
    add(0,0,1,0,0, 0, 2,0,0,2'b00);
    // Load 5, two ticks, pause across three ticks, resume.
    add(0,1,0,0,0, 5, 5,1,0,2'b01);
    add(1,0,0,0,0, 0, 4,1,0,2'b01);
    add(1,0,0,0,0, 0, 3,1,0,2'b01);
    add(1,0,0,1,0, 0, 3,1,0,2'b10);
    add(1,0,0,1,0, 0, 3,1,0,2'b10);
    add(1,0,0,1,0, 0, 3,1,0,2'b10);
    add(0,0,0,0,0, 0, 3,1,0,2'b01);
    add(1,0,0,0,0, 0, 2,1,0,2'b01);
    add(1,0,0,0,0, 0, 1,1,0,2'b01);
    add(1,0,0,0,0, 0, 0,0,1,2'b00);
    // Load 4, stop+start+tick together, then start with zero.
    add(0,1,0,0,0, 4, 4,1,0,2'b01);
    add(1,1,1,0,0, 9, 4,0,0,2'b00);
    add(0,1,0,0,0, 0, 4,0,0,2'b00);
    // Zero load while paused acts as abort.
    add(0,1,0,0,0, 6, 6,1,0,2'b01);
    add(0,0,0,1,0, 0, 6,1,0,2'b10);
    add(0,1,0,1,0, 0, 6,0,0,2'b00);

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pack(2'b00, 1'b0, 1'b0, 1'b0, '0));
    check_outputs("reset_state");
    reset = 1'b0;

    foreach (tbl[k]) begin
      step(tbl[k].tick, tbl[k].start, tbl[k].stop, tbl[k].pause, tbl[k].periodic,
           tbl[k].lv, 1'b0, $sformatf("vec%0d_model", k));
      n_checks++;
      if ({dbg_state, u_if.busy, u_if.done, u_if.count} !==
          {tbl[k].e_state, tbl[k].e_busy, tbl[k].e_done, tbl[k].e_count}) begin
        n_errors++;
        $display("FAIL vec%0d: state=%0d busy=%b done=%b count=%0d expected state=%0d busy=%b done=%b count=%0d",
                 k, dbg_state, u_if.busy, u_if.done, u_if.count,
                 tbl[k].e_state, tbl[k].e_busy, tbl[k].e_done, tbl[k].e_count);
      end
    end

    // Restart on the terminal tick suppresses done; then reset mid-count.
    step(0,1,0,0,0, 8'd1, 0, "restart_load1");
    step(1,1,0,0,0, 8'd7, 0, "restart_on_terminal");
    check_bit("restart_no_done", u_if.done, 1'b0);
    check_bit("restart_busy", u_if.busy, 1'b1);
    step(1,0,0,0,0, 8'd0, 0, "after_restart_tick");
    pulse_reset("reset_mid_count");
    check_bit("reset_busy_low", u_if.busy, 1'b0);

    // Reset while done is high kills the pulse immediately.
    step(0,1,0,0,0, 8'd1, 0, "load1_again");
    step(1,0,0,0,0, 8'd0, 0, "terminal_done");
    check_bit("done_seen", u_if.done, 1'b1);
    pulse_reset("reset_during_done");

`ifdef TICK_TIMER_STICKY_IRQ_EN
    step(0,1,0,0,0, 8'd1, 0, "irq_load1");
    step(1,0,0,0,0, 8'd0, 0, "irq_set");
    check_bit("irq_rises", w_irq, 1'b1);
    for (int i = 0; i < 10; i++) step(0,0,0,0,0, 8'd0, 0, "irq_hold");
    check_bit("irq_held", w_irq, 1'b1);
    step(0,0,0,0,0, 8'd0, 1, "irq_ack");
    check_bit("irq_cleared", w_irq, 1'b0);
    step(0,1,0,0,1, 8'd1, 0, "irq_periodic_load");
    step(1,0,0,0,0, 8'd0, 1, "irq_set_with_ack");
    check_bit("irq_set_wins", w_irq, 1'b1);
    step(0,0,1,0,0, 8'd0, 0, "irq_stop_keeps");
    check_bit("irq_survives_stop", w_irq, 1'b1);
    step(0,0,0,0,0, 8'd0, 1, "irq_ack2");
`endif

    // Randomized traffic against the model.
    begin
      logic p_lvl;
      p_lvl = 1'b0;
      for (int i = 0; i < 600; i++) begin
        logic [W-1:0] lv;
        if ($urandom_range(0, 7) == 0) p_lvl = ~p_lvl;
        lv = ($urandom_range(0, 5) == 0) ? W'(0) :
             (($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(1, 6)));
        if (i == 300) pulse_reset("rand_reset");
        step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 24) == 0, p_lvl, 1'($urandom_range(0, 1)), lv,
             $urandom_range(0, 3) == 0, "random");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/tick_timer.md
Name: tick_timer

Overview:
- Programmable countdown timer driven by a one-cycle enable tick from the divide-by-N tick generator directly upstream.
- Consumes the generator's `y` pulse on `tick` and counts down a loaded value.
- Emits a one-cycle `done` pulse at terminal count.
- Runs one-shot or periodic, with pause/resume and abort.

Parameters:
- W, 8, width of load value and counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle enable pulse from upstream divider; counter decrements only when high.
- start  input  1  one-cycle request: latch load_val and begin counting.
- stop  input  1  one-cycle request: abort and return to IDLE.
- pause  input  1  level: freeze counting while high (RUN/PAUSED only).
- periodic  input  1  sampled at start; 1 = auto-reload, 0 = one-shot.
- load_val  input  W  initial count; sampled only on accepted start.
- count  output  W  current remaining count.
- busy  output  1  high in RUN or PAUSED.
- done  output  1  one-cycle pulse at terminal count.

Behaviour:
- One clock domain `clk`. Reset is asynchronous, active-high, port name `reset`. On reset, regardless of state:
  - state = IDLE, count = 0, done = 0, busy = 0.
  - Internal reload register = 0, mode bit = 0.
- States are IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10. Any other encoding goes to IDLE on the next clock.
- Priority per cycle is stop > start > pause > tick.
- IDLE:
  - start=1 with load_val!=0: count<=load_val, reload<=load_val, mode<=periodic, state -> RUN.
  - start=1 with load_val==0: ignored; stay in IDLE, no done.
  - tick and pause are ignored in IDLE.
- RUN:
  - stop=1: state -> IDLE, count holds its value, no done.
  - start=1 (no stop): restart. count<=load_val, reload/mode re-latched, no done even if tick coincides with terminal count. load_val==0 here behaves as stop.
  - pause=1: state -> PAUSED. A tick in that same cycle is dropped.
  - tick=1 with count>1: count<=count-1.
  - tick=1 with count==1 (terminal): done<=1 for exactly one cycle. Then:
    - One-shot: count<=0, state -> IDLE.
    - Periodic: count<=reload, stay in RUN.
- PAUSED:
  - Ticks are ignored and count holds.
  - pause=0 -> RUN on the next clock. Counting resumes from the held count on the first tick after return to RUN.
  - stop and start are honoured exactly as in RUN.
- Latency:
  - done is registered and asserts on the clock edge that samples the terminal tick. It is visible the cycle after tick is high.
  - count updates on the same edge.
- busy is combinational: state==RUN or state==PAUSED.
- Changes to load_val or periodic while busy have no effect until the next accepted start.
- Reset asserted mid-count clears everything immediately, with no done pulse. After reset releases, the block waits in IDLE for start.
- W-bit arithmetic. count never wraps below 0, because reload or IDLE occurs at 1->0.

Optional Feature:
- Macro: TICK_TIMER_STICKY_IRQ_EN.
- When defined, the block adds:
  - Input `irq_ack` (1 bit) and output `irq` (1 bit).
  - `irq` is set on the same edge as done, and stays set until a cycle with irq_ack=1.
  - If set and ack coincide, set wins.
  - `irq` resets to 0.
  - Stop and start do not clear `irq`.
- When not defined, these ports do not exist and `done` is the only completion indication.

Test Plan:
- Reset, then start=1 with load_val=3, periodic=0, and tick every 3rd clk (divide-by-3 source) -> count goes 3,2,1,0 across 3 ticks. done is high exactly 1 cycle after the third tick, then busy=0 and state=IDLE.
- Periodic with load_val=2 for 6 ticks -> done pulses after ticks 2, 4, 6. count sequence is 2,1,2,1,2,1,2. busy stays 1.
- Load 5, after 2 ticks hold pause=1 across 3 ticks, then release -> count holds 3 while paused. done fires after 3 further ticks. busy=1 throughout.
- Load 4, assert stop and start together with a tick -> stop wins: IDLE, count=4 held, no done. Then start with load_val=0 -> stays IDLE.
- Load 1, assert start with load_val=7 on the same cycle as the terminal tick -> no done, count=7, RUN. Assert reset mid-count -> count=0, busy=0, done=0 immediately.
- With TICK_TIMER_STICKY_IRQ_EN, load 1 and tick once -> irq rises with done and stays high for 10 cycles until irq_ack=1. Asserting ack on the same cycle as a new done keeps irq=1.
